// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipelined ARM-subset core: ALU opcodes,
// condition codes, forwarding selects and NZCV bit positions.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  typedef enum logic [1:0] {
    FWD_RD  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_RSV = 2'b11
  } fwd_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/execute_stage_if.sv
// Decode-to-Execute inputs, forwarding inputs and Execute-to-Memory outputs.
// The master side is whatever drives the E-side (Decode or a bench).
interface execute_stage_if #(parameter int DATA_W = 32);

  logic [DATA_W-1:0] RD1E;
  logic [DATA_W-1:0] RD2E;
  logic [DATA_W-1:0] ExtImmE;
  logic              ALUSrcE;
  logic [1:0]        ALUControlE;
  logic [1:0]        FlagWriteE;
  logic [3:0]        CondE;
  logic              PCSrcE;
  logic              RegWriteE;
  logic              MemtoRegE;
  logic              MemWriteE;
  logic              BranchE;
  logic [3:0]        WA3E;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic [DATA_W-1:0] ResultW;

  logic              BranchTakenE;
  logic [3:0]        Flags;
  logic [DATA_W-1:0] ALUResultM;
  logic [DATA_W-1:0] WriteDataM;
  logic [3:0]        WA3M;
  logic              PCSrcM;
  logic              RegWriteM;
  logic              MemtoRegM;
  logic              MemWriteM;

  modport master (
    output RD1E, RD2E, ExtImmE, ALUSrcE, ALUControlE, FlagWriteE, CondE,
           PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, WA3E,
           ForwardAE, ForwardBE, ResultW,
    input  BranchTakenE, Flags, ALUResultM, WriteDataM, WA3M,
           PCSrcM, RegWriteM, MemtoRegM, MemWriteM
  );

  modport slave (
    input  RD1E, RD2E, ExtImmE, ALUSrcE, ALUControlE, FlagWriteE, CondE,
           PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, WA3E,
           ForwardAE, ForwardBE, ResultW,
    output BranchTakenE, Flags, ALUResultM, WriteDataM, WA3M,
           PCSrcM, RegWriteM, MemtoRegM, MemWriteM
  );

endinterface

// File: rtl/execute_stage_cond_unit.sv
// Owns the architectural NZCV register, decodes the condition field against
// it, and applies flag writes only when the instruction's condition passes.
module cond_unit
  import pipeline_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] alu_flags,
  input  logic [3:0] CondE,
  input  logic [1:0] FlagWriteE,
  output logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  // Condition check always uses the committed flags, so a flag-setting
  // instruction is seen by the very next one without a bubble.
  always_comb begin
    n = Flags[FLAG_N];
    z = Flags[FLAG_Z];
    c = Flags[FLAG_C];
    v = Flags[FLAG_V];
    CondEx = 1'b0;
    case (cond_t'(CondE))
      COND_EQ: CondEx = z;
      COND_NE: CondEx = !z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = !c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = !n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = !v;
      COND_HI: CondEx = c & !z;
      COND_LS: CondEx = !c | z;
      COND_GE: CondEx = (n == v);
      COND_LT: CondEx = (n != v);
      COND_GT: CondEx = !z & (n == v);
      COND_LE: CondEx = z | (n != v);
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

  // NZ and CV are written as independent pairs; a failed condition leaves both untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Flags <= FLAGS_RST;
    end else begin
      if (FlagWriteE[1] && CondEx) begin
        Flags[FLAG_N] <= alu_flags[FLAG_N];
        Flags[FLAG_Z] <= alu_flags[FLAG_Z];
      end
      if (FlagWriteE[0] && CondEx) begin
        Flags[FLAG_C] <= alu_flags[FLAG_C];
        Flags[FLAG_V] <= alu_flags[FLAG_V];
      end
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, 2-bit-op ALU with NZCV, condition
// gating of side effects, branch-taken to Fetch, and the EX/MEM register.
module execute_stage
  import pipeline_pkg::*;
#(
  parameter int         DATA_W    = 32,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic         clk,
  input  logic         reset,
  execute_stage_if.slave bus
);

  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] b_operand;
  logic [DATA_W-1:0] src_b;
  logic [DATA_W-1:0] adder_b;
  logic [DATA_W:0]   sum;
  logic              is_sub;
  logic [DATA_W-1:0] alu_result;
  logic [3:0]        alu_flags;
  logic              cond_ex;

  // Operand forwarding; the reserved select 11 falls back to the register value.
  always_comb begin
    case (fwd_t'(bus.ForwardAE))
      FWD_WB:  src_a = bus.ResultW;
      FWD_MEM: src_a = bus.ALUResultM;
      default: src_a = bus.RD1E;
    endcase
    case (fwd_t'(bus.ForwardBE))
      FWD_WB:  b_operand = bus.ResultW;
      FWD_MEM: b_operand = bus.ALUResultM;
      default: b_operand = bus.RD2E;
    endcase
    src_b = bus.ALUSrcE ? bus.ExtImmE : b_operand;
  end

  // Shared adder: subtraction is A + ~B + 1, so carry-out means "no borrow".
  always_comb begin
    is_sub  = (alu_op_t'(bus.ALUControlE) == ALU_SUB);
    adder_b = is_sub ? ~src_b : src_b;
    sum     = {1'b0, src_a} + {1'b0, adder_b} + {{DATA_W{1'b0}}, is_sub};
    alu_result = sum[DATA_W-1:0];
    alu_flags  = 4'b0000;
    case (alu_op_t'(bus.ALUControlE))
      ALU_AND: alu_result = src_a & src_b;
      ALU_ORR: alu_result = src_a | src_b;
      default: begin
        alu_flags[FLAG_C] = sum[DATA_W];
        alu_flags[FLAG_V] = (src_a[DATA_W-1] == adder_b[DATA_W-1]) &&
                            (sum[DATA_W-1] != src_a[DATA_W-1]);
      end
    endcase
    alu_flags[FLAG_N] = alu_result[DATA_W-1];
    alu_flags[FLAG_Z] = (alu_result == '0);
  end

  cond_unit #(.FLAGS_RST(FLAGS_RST)) u_cond (
    .clk        (clk),
    .reset      (reset),
    .alu_flags  (alu_flags),
    .CondE      (bus.CondE),
    .FlagWriteE (bus.FlagWriteE),
    .Flags      (bus.Flags),
    .CondEx     (cond_ex)
  );

  assign bus.BranchTakenE = bus.BranchE & cond_ex;

  // EX/MEM register; side-effecting controls are squashed when the condition fails.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.ALUResultM <= '0;
      bus.WriteDataM <= '0;
      bus.WA3M       <= '0;
      bus.PCSrcM     <= 1'b0;
      bus.RegWriteM  <= 1'b0;
      bus.MemtoRegM  <= 1'b0;
      bus.MemWriteM  <= 1'b0;
    end else begin
      bus.ALUResultM <= alu_result;
      bus.WriteDataM <= b_operand;
      bus.WA3M       <= bus.WA3E;
      bus.PCSrcM     <= bus.PCSrcE & cond_ex;
      bus.RegWriteM  <= bus.RegWriteE & cond_ex;
      bus.MemtoRegM  <= bus.MemtoRegE;
      bus.MemWriteM  <= bus.MemWriteE & cond_ex;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboarded bench for execute_stage: directed scenarios followed by random
// instructions, checked against an arithmetic reference model.
module tb_execute_stage;
  import pipeline_pkg::*;

  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  execute_stage_if #(.DATA_W(DATA_W)) bus ();

  execute_stage #(.DATA_W(DATA_W), .FLAGS_RST(4'b0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rd1, rd2, imm, resw;
    logic        alusrc;
    logic [1:0]  op, fw, fa, fb;
    logic [3:0]  cond, wa3;
    logic        pcsrc, regw, memtoreg, memw, branch;
  } stim_t;

  typedef struct {
    logic [31:0] alu, wd;
    logic [3:0]  wa3, flags;
    logic        pcsrc, regw, memtoreg, memw;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  logic [3:0]  m_flags = 4'b0000;
  logic [31:0] m_alum = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit condHolds(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one instruction now, predict its EX/MEM effect and queue it.
  task automatic driveAndPush(input stim_t s);
    logic [31:0] a, bop, b, res;
    longint      full, sv;
    bit          ce, c, v;
    logic [3:0]  nf;
    exp_t        e;
    bus.RD1E = s.rd1; bus.RD2E = s.rd2; bus.ExtImmE = s.imm; bus.ResultW = s.resw;
    bus.ALUSrcE = s.alusrc; bus.ALUControlE = s.op; bus.FlagWriteE = s.fw;
    bus.ForwardAE = s.fa; bus.ForwardBE = s.fb; bus.CondE = s.cond; bus.WA3E = s.wa3;
    bus.PCSrcE = s.pcsrc; bus.RegWriteE = s.regw; bus.MemtoRegE = s.memtoreg;
    bus.MemWriteE = s.memw; bus.BranchE = s.branch;
    a   = (s.fa == 2'd1) ? s.resw : (s.fa == 2'd2) ? m_alum : s.rd1;
    bop = (s.fb == 2'd1) ? s.resw : (s.fb == 2'd2) ? m_alum : s.rd2;
    b   = s.alusrc ? s.imm : bop;
    ce  = condHolds(s.cond, m_flags);
    c = 0; v = 0;
    case (s.op)
      2'd0: begin
        full = longint'(a) + longint'(b);
        res  = full[31:0];
        c    = (full >> 32) != 0;
        sv   = longint'($signed(a)) + longint'($signed(b));
        v    = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      2'd1: begin
        res = a - b;
        c   = (a >= b);
        sv  = longint'($signed(a)) - longint'($signed(b));
        v   = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      2'd2: res = a & b;
      default: res = a | b;
    endcase
    nf = m_flags;
    if (s.fw[1] && ce) begin nf[3] = res[31]; nf[2] = (res == 0); end
    if (s.fw[0] && ce) begin nf[1] = c; nf[0] = v; end
    e.alu = res; e.wd = bop; e.wa3 = s.wa3; e.flags = nf;
    e.pcsrc = s.pcsrc & ce; e.regw = s.regw & ce; e.memtoreg = s.memtoreg; e.memw = s.memw & ce;
    sbq.push_back(e);
    #1 checkOutput("BranchTakenE", {31'b0, bus.BranchTakenE}, {31'b0, s.branch & ce});
    m_flags = nf;
    m_alum  = res;
  endtask

  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    driveAndPush(s);
  endtask

  function automatic stim_t aluOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] fw, input logic [3:0] cond);
    stim_t s;
    s = '{default: 0};
    s.op = op; s.rd1 = a; s.rd2 = b; s.fw = fw; s.cond = cond; s.wa3 = 4'd3;
    return s;
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ALUResultM"}, bus.ALUResultM, 32'h0);
    checkOutput({tag, "_WriteDataM"}, bus.WriteDataM, 32'h0);
    checkOutput({tag, "_WA3M"}, {28'b0, bus.WA3M}, 32'h0);
    checkOutput({tag, "_ctrlM"}, {28'b0, bus.PCSrcM, bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM}, 32'h0);
    checkOutput({tag, "_Flags"}, {28'b0, bus.Flags}, 32'h0);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every edge outside reset the DUT presents one EX/MEM result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset && sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput("ALUResultM", bus.ALUResultM, e.alu);
        checkOutput("WriteDataM", bus.WriteDataM, e.wd);
        checkOutput("WA3M", {28'b0, bus.WA3M}, {28'b0, e.wa3});
        checkOutput("Flags", {28'b0, bus.Flags}, {28'b0, e.flags});
        checkOutput("RegWriteM", {31'b0, bus.RegWriteM}, {31'b0, e.regw});
        checkOutput("MemWriteM", {31'b0, bus.MemWriteM}, {31'b0, e.memw});
        checkOutput("PCSrcM", {31'b0, bus.PCSrcM}, {31'b0, e.pcsrc});
        checkOutput("MemtoRegM", {31'b0, bus.MemtoRegM}, {31'b0, e.memtoreg});
      end
    end
  end

  initial begin
    stim_t s;
    s = '{default: 0};
    bus.RD1E = '0; bus.RD2E = '0; bus.ExtImmE = '0; bus.ResultW = '0;
    bus.ALUSrcE = 0; bus.ALUControlE = '0; bus.FlagWriteE = '0; bus.ForwardAE = '0;
    bus.ForwardBE = '0; bus.CondE = '0; bus.WA3E = '0; bus.PCSrcE = 0; bus.RegWriteE = 0;
    bus.MemtoRegE = 0; bus.MemWriteE = 0; bus.BranchE = 0;
    #1 checkResetOutputs("por");

    // Overflowing ADD via immediate: expect 0x80000000 and NZCV=1001.
    s = aluOp(2'd0, 32'h7FFF_FFFF, 32'h0, 2'b11, 4'hE);
    s.alusrc = 1; s.imm = 32'h1; s.rd2 = 32'h55;
    @(negedge clk);
    reset = 1'b1;
    driveAndPush(s);

    // SUB 5-5 sets Z, then EQ passes and NE fails.
    applyStimulus(aluOp(2'd1, 32'd5, 32'd5, 2'b11, 4'hE));
    s = aluOp(2'd0, 32'd7, 32'd8, 2'b00, 4'h0); s.regw = 1;
    applyStimulus(s);
    s = aluOp(2'd0, 32'd9, 32'd1, 2'b00, 4'h1); s.regw = 1;
    applyStimulus(s);

    // Forwarding on operand A from each source.
    for (int sel = 1; sel < 4; sel++) begin
      applyStimulus(aluOp(2'd0, 32'h100, 32'h200, 2'b00, 4'hE));
      s = aluOp(2'd0, 32'h1, 32'h4000, 2'b00, 4'hE);
      s.resw = 32'h20; s.fa = sel[1:0];
      applyStimulus(s);
    end

    // LT branch taken with N!=V, not taken with N==V.
    applyStimulus(aluOp(2'd1, 32'hFFFF_FFFF, 32'h1, 2'b11, 4'hE));
    s = aluOp(2'd0, 32'h0, 32'h0, 2'b00, 4'hB); s.branch = 1; s.pcsrc = 1;
    applyStimulus(s);
    applyStimulus(aluOp(2'd1, 32'd5, 32'd5, 2'b11, 4'hE));
    applyStimulus(s);

    // Flags=0100, then a failed-condition SUB must not touch them or memory.
    applyStimulus(aluOp(2'd2, 32'h0, 32'h0, 2'b11, 4'hE));
    s = aluOp(2'd1, 32'd1, 32'd2, 2'b11, 4'h1); s.memw = 1;
    applyStimulus(s);

    // Mid-stream reset with RegWriteM=1 and Flags=1010 pending.
    s = aluOp(2'd1, 32'hFFFF_FFFF, 32'h1, 2'b11, 4'hE); s.regw = 1; s.wa3 = 4'd9;
    applyStimulus(s);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1 checkResetOutputs("midreset");
    m_flags = 4'b0000;
    m_alum  = '0;
    sbq.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    s = aluOp(2'd0, 32'd10, 32'd20, 2'b11, 4'hE); s.regw = 1;
    driveAndPush(s);

    // Random instruction stream.
    for (int i = 0; i < 300; i++) begin
      s.rd1 = pickOperand(); s.rd2 = pickOperand(); s.imm = pickOperand(); s.resw = pickOperand();
      s.alusrc = $urandom_range(0, 1) == 1;
      s.op = 2'($urandom_range(0, 3)); s.fw = 2'($urandom_range(0, 3));
      s.fa = 2'($urandom_range(0, 3)); s.fb = 2'($urandom_range(0, 3));
      s.cond = 4'($urandom_range(0, 15)); s.wa3 = 4'($urandom_range(0, 15));
      s.pcsrc = $urandom_range(0, 1) == 1; s.regw = $urandom_range(0, 1) == 1;
      s.memtoreg = $urandom_range(0, 1) == 1; s.memw = $urandom_range(0, 1) == 1;
      s.branch = $urandom_range(0, 1) == 1;
      applyStimulus(s);
    end

    @(posedge clk);
    #3;
    checkOutput("queue_drained", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 5-stage pipelined ARM-subset processor; sits directly downstream of Decode and consumes its E-side outputs (RD1E, RD2E, ExtImmE, control bits, CondE, WA3E).
- Performs operand forwarding, runs a 2-bit-op ALU with NZCV generation, and evaluates the condition field against the architectural flags register, which this block owns.
- Drives the branch-taken signal to Fetch and registers results into the EX/MEM pipeline register for the Memory stage.
- Returns the current flags to Decode's InFlags.

Parameters:
DATA_W, 32, datapath width (ALU, operands, results)
FLAGS_RST, 4'b0000, NZCV value loaded on reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
RD1E  in  DATA_W  register operand A from Decode
RD2E  in  DATA_W  register operand B / store data from Decode
ExtImmE  in  DATA_W  extended immediate
ALUSrcE  in  1  1 = B operand is ExtImmE
ALUControlE  in  2  00 ADD, 01 SUB, 10 AND, 11 ORR
FlagWriteE  in  2  [1] updates N,Z; [0] updates C,V
CondE  in  4  ARM condition field
PCSrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE  in  1 each  unconditioned control
WA3E  in  4  destination register
ForwardAE, ForwardBE  in  2 each  00 RDxE, 01 ResultW, 10 ALUResultM, 11 treated as 00
ResultW  in  DATA_W  writeback result
BranchTakenE  out  1  BranchE & CondEx (combinational, to Fetch)
Flags  out  4  current NZCV register (to Decode InFlags)
ALUResultM, WriteDataM  out  DATA_W  registered ALU result / forwarded B operand before the immediate mux
WA3M  out  4  registered destination
PCSrcM, RegWriteM, MemtoRegM, MemWriteM  out  1 each  registered, condition-gated control

Behaviour:
- Reset (reset=0, asynchronous): Flags=FLAGS_RST; every M output is 0. The condition is evaluated from the reset flag value in the first cycle after release.
- Forwarding: SrcA=mux(ForwardAE); the B-operand value is mux(ForwardBE); SrcB=ALUSrcE?ExtImmE:B-operand. WriteDataM registers the B-operand value, never the immediate.
- ALU: ADD sum=A+B; SUB sum=A+~B+1.
  - C is the carry-out of the 33-bit sum (SUB: C=1 means no borrow).
  - V=(A[31]==B'[31])&&(sum[31]!=A[31]), where B' is the adder input.
  - AND/ORR: ALU C=V=0.
  - N=res[31]; Z=(res==0).
- Condition (CondEx), evaluated on the current Flags register:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL(1110)=1; 1111=0.
- Flag update at the clock edge:
  - N,Z update only if FlagWriteE[1]&CondEx.
  - C,V update only if FlagWriteE[0]&CondEx.
  - Otherwise flags hold. A failed-condition instruction never alters flags.
- Latency: flags written by instruction i are visible to instruction i+1 in the next cycle (back-to-back CMP; BEQ works with no bubble).
- EX/MEM register (every clock edge, no enable):
  - ALUResultM<=res, WA3M<=WA3E, MemtoRegM<=MemtoRegE.
  - RegWriteM<=RegWriteE&CondEx; MemWriteM<=MemWriteE&CondEx; PCSrcM<=PCSrcE&CondEx.
- Bubbles from a Decode flush arrive as all-zero control; they propagate as zero control and do not touch flags (FlagWriteE=0).
- Reset asserted mid-operation clears Flags and M outputs immediately, independent of clk. In-flight data is discarded.
- Width: all arithmetic is modulo 2^DATA_W; no saturation.

Decomposition:
- Shared package pipeline_pkg holds:
  - ALU opcode constants (ALU_ADD/SUB/AND/ORR).
  - Condition code constants (COND_EQ..COND_AL).
  - Forward-select constants (FWD_RD/FWD_WB/FWD_MEM).
  - Flag bit indices (FLAG_N=3, Z=2, C=1, V=0).
- One sub-module, cond_unit, owns the flags register, the CondEx decode and the gated flag update (inputs: ALU flags, CondE, FlagWriteE).
- The ALU stays inline in execute_stage.

Test Plan:
1. Reset low mid-stream, with RegWriteM=1 and Flags=1010 -> all M outputs 0 and Flags=0000 immediately; after release, ADD with CondE=1110 proceeds normally.
2. ADD, SrcA=0x7FFFFFFF, ALUSrcE=1, ExtImmE=1, FlagWriteE=11, CondE=1110 -> next edge: ALUResultM=0x80000000, Flags=1001 (N=1 Z=0 C=0 V=1).
3. SUB 5-5 (FlagWriteE=11) then ADD CondE=0000 (EQ) RegWriteE=1 -> Flags=0110, RegWriteM=1. Repeat with CondE=0001 (NE) -> RegWriteM=0 and ALUResultM still captured.
4. Forwarding: RD1E=0x1, ResultW=0x20, ALUResultM=0x300, ADD with RD2E=0x4000 -> ForwardAE=01 gives 0x4020; ForwardAE=10 gives 0x4300; ForwardAE=11 gives 0x4001.
5. BranchE=1, PCSrcE=1, CondE=1011 (LT), Flags N=1 V=0 -> BranchTakenE=1 in the same cycle, PCSrcM=1 next edge. With Flags N=V -> both 0.
6. Failed-condition flag write: Flags=0100, SUB 1-2 with CondE=0001 (NE), FlagWriteE=11 -> Flags stays 0100 and MemWriteE=1 is gated to MemWriteM=0.
